// File: rtl/upower_pkg.sv
// Shared types and encodings for the uPower ALU sequencer.
// States, instruction classes and opcode/extended-opcode values.
package upower_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_e;

  typedef enum logic [2:0] {
    C_ILL,
    C_XO,
    C_X,
    C_DALU,
    C_LOAD,
    C_STORE,
    C_BC,
    C_B
  } iclass_e;

  localparam logic [5:0] OP_EXT   = 6'd31;
  localparam logic [5:0] OP_BC    = 6'd19;
  localparam logic [5:0] OP_B     = 6'd18;
  localparam logic [5:0] OP_ADDIC = 6'd14;
  localparam logic [5:0] OP_ADDIS = 6'd15;
  localparam logic [5:0] OP_ANDI  = 6'd28;
  localparam logic [5:0] OP_ORI   = 6'd24;
  localparam logic [5:0] OP_XORI  = 6'd26;
  localparam logic [5:0] OP_LWZ   = 6'd32;
  localparam logic [5:0] OP_LBZ   = 6'd34;
  localparam logic [5:0] OP_LHZ   = 6'd40;
  localparam logic [5:0] OP_LHA   = 6'd42;
  localparam logic [5:0] OP_LD    = 6'd58;
  localparam logic [5:0] OP_STW   = 6'd36;
  localparam logic [5:0] OP_STWU  = 6'd37;
  localparam logic [5:0] OP_STB   = 6'd38;
  localparam logic [5:0] OP_STH   = 6'd44;
  localparam logic [5:0] OP_STD   = 6'd62;

  localparam logic [8:0] XOXO_ADD  = 9'd266;
  localparam logic [8:0] XOXO_SUBF = 9'd40;

  localparam logic [9:0] XOX_AND   = 10'd28;
  localparam logic [9:0] XOX_NAND  = 10'd476;
  localparam logic [9:0] XOX_OR    = 10'd444;
  localparam logic [9:0] XOX_XOR   = 10'd316;
  localparam logic [9:0] XOX_EXTSW = 10'd986;

  function automatic logic is_alu(input iclass_e c);
    return (c == C_XO) || (c == C_X) || (c == C_DALU);
  endfunction

endpackage

// File: rtl/upower_decoder.sv
// Combinational instruction classifier.
// XO is checked ahead of X so it wins when both fields match.
module upower_decoder
  import upower_pkg::*;
(
  input  logic [31:0] instr,
  output iclass_e     iclass
);

  logic [5:0] op;
  logic [9:0] xox;
  logic [8:0] xoxo;
  logic is_xo, is_x, is_dalu;
  logic is_ld, is_st, is_bc, is_b;

  assign op   = instr[31:26];
  assign xox  = instr[10:1];
  assign xoxo = instr[9:1];

  assign is_xo = (op == OP_EXT) &&
    (xoxo == XOXO_ADD || xoxo == XOXO_SUBF);

  assign is_x = (op == OP_EXT) && !is_xo &&
    (xox == XOX_AND  || xox == XOX_NAND ||
     xox == XOX_OR   || xox == XOX_XOR  ||
     xox == XOX_EXTSW);

  assign is_dalu =
    op == OP_ADDIC || op == OP_ADDIS ||
    op == OP_ANDI  || op == OP_ORI   ||
    op == OP_XORI;

  assign is_ld =
    op == OP_LWZ || op == OP_LBZ ||
    op == OP_LHZ || op == OP_LHA ||
    op == OP_LD;

  assign is_st =
    op == OP_STW || op == OP_STWU ||
    op == OP_STB || op == OP_STH  ||
    op == OP_STD;

  assign is_bc = (op == OP_BC);
  assign is_b  = (op == OP_B);

  always_comb begin
    iclass = C_ILL;
    unique case (1'b1)
      is_xo:   iclass = C_XO;
      is_x:    iclass = C_X;
      is_dalu: iclass = C_DALU;
      is_ld:   iclass = C_LOAD;
      is_st:   iclass = C_STORE;
      is_bc:   iclass = C_BC;
      is_b:    iclass = C_B;
      default: iclass = C_ILL;
    endcase
  end

endmodule

// File: rtl/upower_alu_sequencer.sv
// Multi-cycle control sequencer for a uPower 64-bit ALU.
// Moore-style control outputs; MEM exit also looks at mem_ack.
module upower_alu_sequencer
  import upower_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [5:0]  dec_opcode,
  output logic [4:0]  dec_rs,
  output logic [4:0]  dec_rt,
  output logic [4:0]  dec_bo,
  output logic [4:0]  dec_bi,
  output logic [15:0] dec_si,
  output logic [13:0] dec_ds,
  output logic [9:0]  dec_xox,
  output logic [8:0]  dec_xoxo,
  output logic        dec_aa,
  output logic [1:0]  dec_xods,
  input  logic        alu_branch,
  output logic        rf_we,
  output logic [4:0]  rf_wsel,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        pc_update,
  output logic        pc_branch,
  output logic        done,
  output logic        err
);

  state_e  state, nxt;
  iclass_e cls_d, cls_q;
  logic    armed;
  logic    hs;
  logic    expired;
  logic [7:0] mcnt;

  // armed delays instr_ready to the first edge after reset release
  assign instr_ready = armed && (state == S_IDLE);
  assign hs          = instr_valid && instr_ready;
  assign expired     = (mcnt == 8'(MEM_TIMEOUT));

  upower_decoder u_dec (
    .instr  (instr),
    .iclass (cls_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      armed <= 1'b0;
    end else begin
      state <= nxt;
      armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cls_q      <= C_ILL;
      dec_opcode <= '0;
      dec_rs     <= '0;
      dec_rt     <= '0;
      dec_si     <= '0;
      dec_ds     <= '0;
      dec_xox    <= '0;
      dec_xoxo   <= '0;
      dec_aa     <= 1'b0;
      dec_xods   <= '0;
    end else if (hs) begin
      cls_q      <= cls_d;
      dec_opcode <= instr[31:26];
      dec_rs     <= instr[25:21];
      dec_rt     <= instr[20:16];
      dec_si     <= instr[15:0];
      dec_ds     <= instr[15:2];
      dec_xox    <= instr[10:1];
      dec_xoxo   <= instr[9:1];
      dec_aa     <= instr[1];
      dec_xods   <= instr[1:0];
    end
  end

  assign dec_bo  = dec_rs;
  assign dec_bi  = dec_rt;
  assign rf_wsel = dec_rs;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcnt <= '0;
    end else if (state != S_MEM) begin
      mcnt <= '0;
    end else if (!mem_ack && !expired) begin
      mcnt <= mcnt + 8'd1;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:
        if (hs) nxt = S_DECODE;
      S_DECODE:
        nxt = (cls_q == C_ILL) ? S_IDLE : S_EXEC;
      S_EXEC:
        if (is_alu(cls_q))
          nxt = S_WB;
        else if (cls_q == C_LOAD || cls_q == C_STORE)
          nxt = S_MEM;
        else
          nxt = S_IDLE;
      S_MEM:
        if (mem_ack)
          nxt = (cls_q == C_LOAD) ? S_WB : S_IDLE;
        else if (expired)
          nxt = S_IDLE;
      S_WB:
        nxt = S_IDLE;
      default:
        nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rf_we     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    pc_update = 1'b0;
    pc_branch = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state)
      S_DECODE:
        err = (cls_q == C_ILL);
      S_EXEC:
        if (cls_q == C_BC || cls_q == C_B) begin
          pc_update = 1'b1;
          pc_branch = (cls_q == C_B) ? 1'b1 : alu_branch;
          done      = 1'b1;
        end
      S_MEM: begin
        mem_req = !expired;
        mem_we  = !expired && (cls_q == C_STORE);
        if (mem_ack) begin
          if (cls_q == C_STORE) begin
            done      = 1'b1;
            pc_update = 1'b1;
          end
        end else if (expired) begin
          err = 1'b1;
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        done      = 1'b1;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/upower_alu_sequencer.md
UPOWER_ALU_SEQUENCER -- requirements
Module: upower_alu_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, cycles in MEM without mem_ack before abort (legal range 1..255).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset; one clock domain, no other clock.
REQ-004 instr_valid/instr_ready  input/output  1/1  instruction handshake; transfer when both are high on a clk edge.
REQ-005 instr  input  32  instruction word.
REQ-006 dec_opcode/dec_rs/dec_rt/dec_bo/dec_bi  output  6/5/5/5/5  registered fields driven to the 64-bit ALU.
REQ-007 dec_si/dec_ds/dec_xox/dec_xoxo/dec_aa/dec_xods  output  16/14/10/9/1/2  registered fields driven to the 64-bit ALU.
REQ-008 alu_branch  input  1  ALU branch outcome, valid in EXEC.
REQ-009 rf_we/rf_wsel  output  1/5  register-file write strobe and destination.
REQ-010 mem_req/mem_we/mem_ack  output/output/input  1/1/1  data-memory request handshake.
REQ-011 pc_update/pc_branch  output  1/1  PC advance pulse; pc_branch=1 selects the branch target.
REQ-012 done/err  output  1/1  one-cycle completion / abort pulses.

Function
REQ-013 Field map: opcode=instr[31:26], rs=bo=instr[25:21], rt=bi=instr[20:16], si=instr[15:0], ds=instr[15:2], xods=instr[1:0], xox=instr[10:1], xoxo=instr[9:1], aa=instr[1]; rf_wsel=instr[25:21].
REQ-014 FSM states are IDLE, DECODE, EXEC, MEM, WB; instr_ready is high only in IDLE with reset_n high.
REQ-015 IDLE->DECODE on handshake; dec_* latch on the same edge and hold until the next handshake.
REQ-016 DECODE class rules: XO (op 31, xoxo 266/40); X (op 31, xoxo not XO, xox 28/476/444/316/986); DALU (op 14/15/28/24/26); LOAD (op 32/34/40/42/58); STORE (op 36/37/38/44/62); BC (op 19); B (op 18).
REQ-017 XO takes priority over X when both fields match.
REQ-018 Any other encoding is illegal: DECODE->IDLE, err pulses 1 cycle, no rf_we/mem_req/pc_update.
REQ-019 Legal instructions: DECODE->EXEC; EXEC lasts exactly one cycle.
REQ-020 EXEC->WB for XO/X/DALU; EXEC->MEM for LOAD/STORE; EXEC->IDLE for BC/B.
REQ-021 On BC/B leaving EXEC: pc_update=1 for one cycle; pc_branch=alu_branch for BC and 1 for B.
REQ-022 MEM: mem_req held high; mem_we=1 for STORE, 0 for LOAD; exit on the first cycle mem_ack=1.
REQ-023 MEM exit: LOAD->WB; STORE->IDLE with done and pc_update pulsed.
REQ-024 MEM timeout: 8-bit counter clears on MEM entry and increments each MEM cycle without ack.
REQ-025 At count==MEM_TIMEOUT: mem_req drops, err pulses, ->IDLE, no WB/pc_update.
REQ-026 mem_ack on the expiry cycle wins over timeout; mem_ack outside MEM is ignored.
REQ-027 WB: rf_we=1 for exactly one cycle, then ->IDLE with done and pc_update (pc_branch=0) pulsed in WB.
REQ-028 Latency from handshake edge: ALU op rf_we in cycle 3; branch pc_update in cycle 2; load WB at cycle 3+memory wait+1.
REQ-029 Back-to-back: new handshake is accepted in the first IDLE cycle after done/err.

Reset
REQ-030 reset_n low asynchronously forces IDLE and zeros every output, all dec_* fields and the timeout counter.
REQ-031 Reset mid-MEM drops mem_req immediately; the pending access is abandoned without err.
REQ-032 instr_ready rises on the first clk edge after reset_n deasserts.

Structure
REQ-033 Package upower_pkg holds the state enum, instruction-class enum and opcode/xox/xoxo constants.
REQ-034 Classification lives in one combinational sub-module, upower_decoder (instr in, class out).

Verification
REQ-035 ADD: op31 xoxo266 rs=3 rt=5 -> dec fields held; rf_we=1, rf_wsel=3 in cycle 3; done same cycle.
REQ-036 BC: op19 aa=0, alu_branch=1 -> pc_update=1, pc_branch=1 in cycle 2; rf_we and mem_req stay 0.
REQ-037 SW: op36 rt=8 si=1000, mem_ack after 4 cycles -> mem_we=1, mem_req high 4 cycles, done; no rf_we.
REQ-038 LW: op32 with mem_ack never asserted and MEM_TIMEOUT=15 -> err after 15 MEM cycles; no rf_we.
REQ-039 Illegal: op 5 -> err 1 cycle after DECODE, then instr_ready=1; reset_n pulsed low mid-MEM -> mem_req=0 asynchronously.
